// File: rtl/hall98_exec_unit.sv
// hall98 execution core: N-entry register file, 3-bit opcode, valid/ready
// instruction handshake, iterative shift-add multiplier, status flags and a
// sticky halt state. Registers are readable through a combinational debug port.
//
// state | meaning
// IDLE  | ready for an instruction; halt_req has priority over op_valid
// EXEC  | single-cycle op latched; write back on the next edge
// MUL   | shift-add multiply, one multiplier bit per cycle, then write back
// HALT  | stopped until reset; all inputs ignored
module hall98_exec_unit #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int RW = $clog2(NREGS)
) (
  input  logic             iclock,
  input  logic             ireset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    rs,
  input  logic [WIDTH-1:0] imm,
  input  logic             halt_req,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             halted,
  input  logic [RW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MOVR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic accept;
  logic wb_en;
  logic mul_step;

  logic [WIDTH-1:0] regs [NREGS];

  logic [2:0]         op_q;
  logic [RW-1:0]      rd_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   imm_q;

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH-1:0]   rd_val;
  logic [WIDTH-1:0]   rs_val;
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [WIDTH-1:0]   wb_val;
  logic               wb_c;

  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic               flag_z_q;
  logic               flag_c_q;

  // Indices past the end of the file read as zero and never write; only
  // reachable when NREGS is not a power of two.
  function automatic logic idx_ok(input logic [RW-1:0] idx);
    return 32'(idx) < NREGS;
  endfunction

  // Operand and debug reads; out-of-range indices return zero.
  always_comb begin
    rd_val   = idx_ok(rd)       ? regs[rd]       : '0;
    rs_val   = idx_ok(rs)       ? regs[rs]       : '0;
    dbg_data = idx_ok(dbg_addr) ? regs[dbg_addr] : '0;
  end

  // State register.
  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control strobes.
  always_comb begin
    state_d  = state_q;
    op_ready = 1'b0;
    halted   = 1'b0;
    accept   = 1'b0;
    wb_en    = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        op_ready = 1'b1;
        if (halt_req) begin
          state_d = S_HALT;
        end else if (op_valid) begin
          accept  = 1'b1;
          state_d = (op == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        wb_en   = 1'b1;
        state_d = S_IDLE;
      end
      S_MUL: begin
        // Counter runs WIDTH..1 for the iterations; terminal count 0 is the
        // writeback cycle.
        if (cnt_q == '0) begin
          wb_en   = 1'b1;
          state_d = S_IDLE;
        end else begin
          mul_step = 1'b1;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Instruction latch: operands are captured at accept so rd==rs is safe.
  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      op_q  <= OP_MOV;
      rd_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
    end else if (accept) begin
      op_q  <= op;
      rd_q  <= rd;
      a_q   <= rd_val;
      b_q   <= rs_val;
      imm_q <= imm;
    end
  end

  // Shift-add multiplier: multiplicand shifts left, multiplier shifts right,
  // LSB first, accumulating into a double-width product.
  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, rd_val};
      mplier_q <= rs_val;
      cnt_q    <= CW'(WIDTH);
    end else if (mul_step) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  // Result and carry selection for the writeback cycle.
  always_comb begin
    add_full = {1'b0, a_q} + {1'b0, b_q};
    sub_full = {1'b0, a_q} - {1'b0, b_q};
    wb_val   = '0;
    wb_c     = 1'b0;
    case (op_q)
      OP_MOV:  wb_val = imm_q;
      OP_ADD: begin
        wb_val = add_full[WIDTH-1:0];
        wb_c   = add_full[WIDTH];
      end
      OP_SUB: begin
        // Borrow out of the extended subtract is exactly B > A.
        wb_val = sub_full[WIDTH-1:0];
        wb_c   = sub_full[WIDTH];
      end
      OP_MUL: begin
        wb_val = acc_q[WIDTH-1:0];
        wb_c   = |acc_q[2*WIDTH-1:WIDTH];
      end
      OP_AND:  wb_val = a_q & b_q;
      OP_OR:   wb_val = a_q | b_q;
      OP_XOR:  wb_val = a_q ^ b_q;
      OP_MOVR: wb_val = b_q;
      default: wb_val = '0;
    endcase
  end

  // Register file write port.
  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && idx_ok(rd_q)) begin
      regs[rd_q] <= wb_val;
    end
  end

  // Status outputs: done pulses at writeback, result and flags hold until the next one.
  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      done_q   <= 1'b0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      done_q <= wb_en;
      if (wb_en) begin
        result_q <= wb_val;
        flag_z_q <= (wb_val == '0);
        flag_c_q <= wb_c;
      end
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;

endmodule

// File: tb/tb_hall98_exec_unit.sv
// Testbench for hall98_exec_unit: a latency-counting reference model checked
// against the DUT every cycle, plus directed scenarios with literal values.
module tb_hall98_exec_unit;

  localparam int WIDTH = 8;
  localparam int NREGS = 4;
  localparam int RW    = 2;
  localparam longint MOD = 256;

  localparam logic [2:0] OP_MOV  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_MOVR = 3'd7;

  logic             iclock = 1'b0;
  logic             ireset = 1'b1;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [2:0]       op = 3'd0;
  logic [RW-1:0]    rd = '0;
  logic [RW-1:0]    rs = '0;
  logic [WIDTH-1:0] imm = '0;
  logic             halt_req = 1'b0;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_c;
  logic             halted;
  logic [RW-1:0]    dbg_addr = '0;
  logic [WIDTH-1:0] dbg_data;

  int checks = 0;
  int failures = 0;
  bit dbg_auto = 1'b1;

  hall98_exec_unit #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .iclock(iclock), .ireset(ireset), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .rd(rd), .rs(rs), .imm(imm), .halt_req(halt_req), .done(done),
    .result(result), .flag_z(flag_z), .flag_c(flag_c), .halted(halted),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 iclock = ~iclock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: an op is accepted when idle, its result computed with
  // plain arithmetic, and committed after a fixed latency.
  int     m_regs [NREGS];
  int     m_result = 0;
  bit     m_z = 0, m_c = 0, m_done = 0, m_halted = 0;
  int     m_left = 0;
  int     p_rd = 0, p_val = 0;
  bit     p_c = 0;

  always @(posedge iclock or posedge ireset) begin : model
    int a, b;
    longint full;
    if (ireset) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
      m_result = 0; m_z = 0; m_c = 0; m_done = 0; m_halted = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_halted) begin
        m_done = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          if (p_rd < NREGS) m_regs[p_rd] = p_val;
          m_result = p_val;
          m_z = (p_val == 0);
          m_c = p_c;
          m_done = 1;
        end
      end else if (halt_req) begin
        m_halted = 1;
      end else if (op_valid) begin
        a = (rd < NREGS) ? m_regs[rd] : 0;
        b = (rs < NREGS) ? m_regs[rs] : 0;
        p_c = 0;
        case (op)
          OP_MOV:  p_val = int'(imm);
          OP_ADD:  begin full = a + b; p_val = int'(full % MOD); p_c = (full >= MOD); end
          OP_SUB:  begin p_val = int'((a - b + MOD) % MOD); p_c = (b > a); end
          OP_MUL:  begin full = longint'(a) * b; p_val = int'(full % MOD); p_c = (full >= MOD); end
          OP_AND:  p_val = a & b;
          OP_OR:   p_val = a | b;
          OP_XOR:  p_val = a ^ b;
          default: p_val = b;
        endcase
        p_rd = int'(rd);
        m_left = (op == OP_MUL) ? WIDTH + 1 : 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge iclock) begin
    chk("op_ready", op_ready, (!m_halted && m_left == 0));
    chk("halted", halted, m_halted);
    chk("done", done, m_done);
    chk("result", result, m_result);
    chk("flag_z", flag_z, m_z);
    chk("flag_c", flag_c, m_c);
    chk("dbg_data", dbg_data, m_regs[dbg_addr]);
    if (dbg_auto) dbg_addr = dbg_addr + 1'b1;
  end

  // Issue one instruction at a negedge; optionally wait for done and check latency.
  task automatic issue(input logic [2:0] o, input int d, input int s, input int im,
                       input int exp_lat, input bit wait_done, input bit halt_after);
    int n, lat;
    op = o; rd = d[RW-1:0]; rs = s[RW-1:0]; imm = im[WIDTH-1:0];
    op_valid = 1'b1;
    n = 0;
    while (!op_ready && n < 50) begin @(negedge iclock); n++; end
    if (n >= 50) chk("accept_timeout", n, 0);
    @(posedge iclock);
    @(negedge iclock);
    op_valid = 1'b0;
    if (halt_after) halt_req = 1'b1;
    chk("busy_ready", op_ready, 0);
    if (wait_done) begin
      lat = 0;
      while (!done && lat < 40) begin @(negedge iclock); lat++; end
      chk("latency", lat, exp_lat);
    end
  endtask

  task automatic dbg_peek(input string name, input int idx, input int exp);
    dbg_auto = 1'b0;
    #1 dbg_addr = idx[RW-1:0];
    #1 chk(name, dbg_data, exp);
    dbg_auto = 1'b1;
  endtask

  initial begin
    @(negedge iclock); @(negedge iclock);
    chk("rst_result", result, 0);
    chk("rst_ready", op_ready, 1);
    chk("rst_halted", halted, 0);
    ireset = 1'b0;
    @(negedge iclock);

    // 1: MOV/MOV/ADD
    issue(OP_MOV, 1, 0, 15, 1, 1, 0);
    chk("t1_mov_res", result, 15);
    issue(OP_MOV, 2, 0, 5, 1, 1, 0);
    issue(OP_ADD, 1, 2, 0, 1, 1, 0);
    chk("t1_add_res", result, 20);
    chk("t1_add_r1", m_regs[1], 20);
    chk("t1_add_z", flag_z, 0);
    chk("t1_add_c", flag_c, 0);

    // 2: SUB without and with borrow
    issue(OP_SUB, 1, 2, 0, 1, 1, 0);
    chk("t2_sub_res", result, 15);
    chk("t2_sub_c", flag_c, 0);
    issue(OP_SUB, 2, 1, 0, 1, 1, 0);
    chk("t2_borrow_res", result, 246);
    chk("t2_borrow_c", flag_c, 1);

    // 3: MUL 15*5, then 16*16 overflow to zero
    issue(OP_MOV, 2, 0, 5, 1, 1, 0);
    issue(OP_MUL, 1, 2, 0, 9, 1, 0);
    chk("t3_mul_res", result, 75);
    chk("t3_mul_c", flag_c, 0);
    issue(OP_MOV, 3, 0, 16, 1, 1, 0);
    issue(OP_MUL, 3, 3, 0, 9, 1, 0);
    chk("t3_sq_res", result, 0);
    chk("t3_sq_z", flag_z, 1);
    chk("t3_sq_c", flag_c, 1);

    // 4: ADD carry, XOR self-clear
    issue(OP_MOV, 0, 0, 200, 1, 1, 0);
    issue(OP_ADD, 0, 0, 0, 1, 1, 0);
    chk("t4_add_res", result, 144);
    chk("t4_add_c", flag_c, 1);
    issue(OP_XOR, 0, 0, 0, 1, 1, 0);
    chk("t4_xor_res", result, 0);
    chk("t4_xor_z", flag_z, 1);
    chk("t4_xor_c", flag_c, 0);

    // Logic ops and register move
    issue(OP_MOV, 0, 0, 240, 1, 1, 0);
    issue(OP_MOV, 3, 0, 60, 1, 1, 0);
    issue(OP_AND, 0, 3, 0, 1, 1, 0);
    chk("and_res", result, 48);
    issue(OP_OR, 0, 3, 0, 1, 1, 0);
    chk("or_res", result, 60);
    issue(OP_MOVR, 2, 3, 0, 1, 1, 0);
    chk("movr_res", result, 60);
    dbg_peek("movr_dbg_r2", 2, 60);

    // 5: reset in the middle of a MUL
    issue(OP_MUL, 1, 2, 0, 0, 0, 0);
    @(negedge iclock); @(negedge iclock);
    #2 ireset = 1'b1;
    #1 chk("t5_ready", op_ready, 1);
    chk("t5_done", done, 0);
    chk("t5_result", result, 0);
    dbg_peek("t5_dbg_r3", 3, 0);
    @(negedge iclock);
    ireset = 1'b0;
    @(negedge iclock);
    issue(OP_MOV, 1, 0, 7, 1, 1, 0);
    dbg_peek("t5_dbg_r1", 1, 7);

    // 6: halt requested during MUL
    issue(OP_MOV, 2, 0, 3, 1, 1, 0);
    issue(OP_MOV, 1, 0, 4, 1, 1, 0);
    issue(OP_MUL, 1, 2, 0, 9, 1, 1);
    chk("t6_mul_res", result, 12);
    chk("t6_not_yet", halted, 0);
    @(negedge iclock);
    chk("t6_halted", halted, 1);
    chk("t6_ready", op_ready, 0);
    op = OP_MOV; rd = 2'd1; imm = 8'd99; op_valid = 1'b1;
    repeat (5) @(negedge iclock);
    halt_req = 1'b0;
    repeat (3) @(negedge iclock);
    op_valid = 1'b0;
    chk("t6_still_halted", halted, 1);
    chk("t6_r1_model", m_regs[1], 12);
    dbg_peek("t6_dbg_r1", 1, 12);
    #2 ireset = 1'b1;
    #1 chk("t6_reset_halted", halted, 0);
    @(negedge iclock);
    ireset = 1'b0;
    repeat (2) @(negedge iclock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hall98_exec_unit.md
Name: hall98_exec_unit

Overview:
Parametrised execution core for the hall98 family. It replaces the fixed 2-bit switch-decoded MOV/ADD/SUB/MUL datapath with an N-entry register file, a 3-bit opcode and a valid/ready instruction handshake. Multiply is an iterative shift-add unit, and the core drives status flags and a sticky halt state. Sits between the instruction source (testbench or fetch stage) and any debug or readback logic.

Parameters:
WIDTH, 8, data and register width in bits (>=4)
NREGS, 4, number of general registers (>=2); index width RW = $clog2(NREGS)

Ports:
iclock  in  1  rising-edge clock
ireset  in  1  asynchronous, active-high reset
op_valid  in  1  instruction present
op_ready  out  1  core can accept an instruction
op  in  3  opcode
rd  in  RW  destination and first-operand register
rs  in  RW  second-operand register
imm  in  WIDTH  immediate for MOV
halt_req  in  1  exit request, level-sensitive
done  out  1  one-cycle pulse at writeback
result  out  WIDTH  last value written back
flag_z  out  1  result == 0
flag_c  out  1  carry (ADD), borrow (SUB), product overflow (MUL)
halted  out  1  core is in HALT
dbg_addr  in  RW  debug read index
dbg_data  out  WIDTH  combinational read of reg[dbg_addr]

Behaviour:
- Reset (asynchronous, any state, including mid-MUL):
  - all registers 0; state IDLE.
  - done=0, result=0, flag_z=0, flag_c=0, halted=0.
  - In-flight operation discarded; no writeback, no done.
- Opcodes (A = reg[rd], B = reg[rs], both latched at accept):
  - 000 MOV rd,imm
  - 001 ADD
  - 010 SUB
  - 011 MUL
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 MOVR rd,rs
- All results are truncated to WIDTH bits and written to rd. rd==rs is legal.
- Index >= NREGS: write suppressed, operand reads return 0, done still pulses.
- States:
  - IDLE: op_ready=1. Priority: if halt_req=1, go to HALT (a simultaneous op_valid is ignored). Otherwise, if op_valid=1, latch op, rd, A, B and imm; go to MUL if op=011, else EXEC.
  - EXEC: at the next edge, write back; done=1 for that cycle; update flags; return to IDLE. Accept-to-done latency is 1 cycle; throughput is 1 op per 2 cycles.
  - MUL: iterate WIDTH cycles using a 2*WIDTH-bit accumulator, one multiplier bit per cycle, LSB first. On the edge after the WIDTH-th iteration, write back the low WIDTH bits, pulse done and return to IDLE. Latency is WIDTH+1 cycles. flag_c = (high WIDTH bits != 0).
  - HALT: op_ready=0, halted=1. Left only by reset. Instructions and halt_req are ignored.
- Flags:
  - Updated only at writeback and held otherwise.
  - ADD: flag_c = bit WIDTH of A+B.
  - SUB: flag_c = (B > A). Result is A-B modulo 2^WIDTH.
  - MUL: flag_c as defined under the MUL state.
  - MOV, MOVR, AND, OR, XOR: flag_c = 0.
  - flag_z is evaluated on the truncated result for every opcode.
- op_ready=0 in EXEC, MUL and HALT. op_valid in those states has no effect, and the source must hold the instruction.
- halt_req asserted while busy takes effect only once the core is back in IDLE. The current op always completes.
- dbg_data reflects register state after the last edge; a writeback is visible the cycle done is high.

Test Plan (WIDTH=8, NREGS=4):
1. MOV r1,15; MOV r2,5; ADD r1,r2 -> r1=20, flag_z=0, flag_c=0; done high exactly 1 cycle after each accept; op_ready low during EXEC.
2. SUB r1,r2 -> r1=15, flag_c=0. Then SUB r2,r1 -> r2=246, flag_c=1 (borrow).
3. MUL r1,r2 with r1=15, r2=5 -> r1=75 exactly 9 cycles after accept, flag_c=0. Then MOV r3,16; MUL r3,r3 -> r3=0, flag_z=1, flag_c=1.
4. MOV r0,200; ADD r0,r0 -> r0=144, flag_c=1. XOR r0,r0 -> 0, flag_z=1, flag_c=0.
5. Assert ireset 3 cycles into a MUL -> all registers 0, no done pulse, op_ready=1 immediately. The next MOV r1,7 gives dbg_data(r1)=7.
6. halt_req raised during MUL -> MUL completes with done, then halted=1 and op_ready=0. Subsequent op_valid is ignored and registers are unchanged until reset.
